uart_file_loader: RTL and testbench
===================================

# uart_file_loader

Hardware responder for the UART file-transfer protocol: on `start` it sends the "send file" request byte (0x02) to the host, receives a 4-byte little-endian file size, then receives the payload. The payload is packed into 32-bit little-endian words and written to a memory write port. It sits between the SoC UART byte interface and main memory, and lets the program image be boot-loaded without the CPU.

## Interface
Parameters:
- `ADDR_W`, 14: word-address width of the memory port.
- `BASE_ADDR`, 0: first word address written.
- `MAX_SIZE`, 2**(ADDR_W+2): largest accepted file size, in bytes.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins a transfer. Ignored unless in IDLE, DONE or ERR.
- `tx_data` out 8: byte to host.
- `tx_valid` out 1: tx byte valid.
- `tx_ready` in 1: UART accepts the tx byte.
- `rx_data` in 8: byte from host.
- `rx_valid` in 1: rx byte valid.
- `rx_ready` out 1: loader accepts the rx byte.
- `mem_valid` out 1: write request.
- `mem_addr` out ADDR_W: word address.
- `mem_wdata` out 32: write data.
- `mem_wstrb` out 4: byte strobes.
- `mem_ready` in 1: write accepted.
- `busy` out 1: high in every state except IDLE, DONE and ERR.
- `done` out 1: one-cycle pulse when the transfer completes.
- `error` out 1: level; high while in ERR.
- `file_size` out 32: size latched from the host.

## Operation
- States: IDLE, REQ, SIZE, DATA, WRITE, DONE, ERR.
- IDLE/DONE/ERR -> REQ on `start`. Entering REQ clears the byte counter, the word address (set to `BASE_ADDR`) and the packing register.
- REQ:
  - drive `tx_data`=0x02 with `tx_valid`=1 until `tx_ready`.
  - On the handshake cycle, go to SIZE.
- SIZE:
  - `rx_ready`=1. Accept 4 bytes; byte k goes to `file_size[8k+7:8k]`.
  - After the 4th byte: if size==0, go to DONE; if size>`MAX_SIZE`, go to ERR; otherwise go to DATA.
- DATA:
  - `rx_ready`=1. Byte n goes to lane n%4 of the packing register, and strobe bit n%4 is set.
  - Go to WRITE when lane 3 is filled, or when the final byte (n==size-1) is accepted.
- WRITE:
  - `rx_ready`=0. `mem_valid`=1 with `mem_addr`, `mem_wdata` and `mem_wstrb` held stable until `mem_ready`.
  - On the handshake: increment the address, clear strobes and packing register. Go to DONE if all bytes have been received, else to DATA.
- DONE: `done` pulses on the entry cycle only. The block then idles in DONE.
- ERR: `error`=1 and no memory writes. Only `start` or `rst` leaves ERR.
- Unwritten lanes of a partial final word carry data 0 and strobe 0.
- Byte counter is 32 bits. Word address wraps modulo 2^ADDR_W; no wrap occurs while size ≤ `MAX_SIZE`.

## Timing
- Reset values:
  - state IDLE.
  - `tx_valid`, `rx_ready`, `mem_valid`, `busy`, `done`, `error` all 0.
  - `tx_data`=0x02; `mem_addr`=`BASE_ADDR`; `mem_wdata`=0; `mem_wstrb`=0; `file_size`=0.
- All outputs are registered or decoded from state only; no combinational path from `rx_valid`, `tx_ready` or `mem_ready` to any output.
- `tx_valid` rises the cycle after `start`.
- `rx_ready` rises the cycle after the tx handshake.
- Handshakes complete on the clock edge where valid and ready are both 1. Either side may hold for any number of cycles.
- `mem_valid` rises the cycle after the completing rx byte. With `mem_ready` tied high, each word costs one extra cycle, so the peak rate is 4 bytes per 5 cycles.
- `done` rises the cycle after the final write handshake, or the cycle after the 4th size byte when size==0.
- `start` while busy is ignored.
- `rst` mid-transfer returns to IDLE immediately: no `done` pulse, and any pending write is dropped.

## Structure
- Shared package `uart_file_pkg`:
  - protocol constants: FT_SEND=0x02, FT_RECV=0x03, FT_END=0x04.
  - state encoding typedef.
- One sub-module, `uart_file_pack`: byte-to-word packer with lane index, strobes and a clear input. All other logic lives in the top FSM.

## Test plan
- Basic load: size 8, bytes 0x11..0x88 -> tx 0x02 once; writes BASE+0 = 0x44332211 (strobe 0xF) and BASE+1 = 0x88776655 (0xF); one `done` pulse.
- Partial word: size 5 -> second write carries wdata 0x00000055, strobe 0x1.
- Zero and oversize:
  - size 0 -> `done` with no writes.
  - size `MAX_SIZE`+1 -> `error`=1, no writes, `rx_ready`=0.
- Backpressure: `mem_ready` held low 10 cycles and random `tx_ready`/`rx_valid` gaps -> `rx_ready` is 0 during WRITE, `mem_*` stays stable, final memory contents are unchanged.
- Reset mid-DATA after 3 bytes -> all outputs return to reset values; a subsequent `start` reloads correctly from `BASE_ADDR`.
- `start` pulsed in DATA -> ignored; the transfer completes normally.

Source files
------------

// File: rtl/uart_file_pkg.sv
// Shared constants and state encoding for the UART file-transfer loader.
package uart_file_pkg;

   localparam logic [7:0] FT_SEND = 8'h02;
   localparam logic [7:0] FT_RECV = 8'h03;
   localparam logic [7:0] FT_END  = 8'h04;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_SIZE,
      ST_DATA,
      ST_WRITE,
      ST_DONE,
      ST_ERR
   } state_t;

endpackage

// File: rtl/uart_file_pack.sv
// Byte-to-word packer: places each byte in its lane and sets that lane's strobe.
module uart_file_pack (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        load,
   input  logic [1:0]  lane,
   input  logic [7:0]  din,
   output logic [31:0] word,
   output logic [3:0]  strb
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word <= '0;
         strb <= '0;
      end else if (clr) begin
         word <= '0;
         strb <= '0;
      end else if (load) begin
         word[{lane, 3'b000} +: 8] <= din;
         strb[lane]                <= 1'b1;
      end
   end

endmodule

// File: rtl/uart_file_loader.sv
// Loads a host-sent file over the UART byte link into memory as 32-bit words.
module uart_file_loader
   import uart_file_pkg::*;
#(
   parameter int          ADDR_W    = 14,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned MAX_SIZE  = 2**(ADDR_W+2)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              mem_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [31:0]       file_size
);

   state_t      state, state_nx;
   logic [31:0] cnt;
   logic [31:0] size_full;
   logic        restart;
   logic        pack_clr;
   logic        pack_load;

   // Outputs depend on state only, so no handshake input reaches an output combinationally
   assign tx_data   = FT_SEND;
   assign tx_valid  = (state == ST_REQ);
   assign rx_ready  = (state == ST_SIZE) || (state == ST_DATA);
   assign mem_valid = (state == ST_WRITE);
   assign error     = (state == ST_ERR);
   assign busy      = !((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));

   assign restart   = start && !busy;
   assign size_full = {rx_data, file_size[23:0]};
   assign pack_clr  = restart || ((state == ST_WRITE) && mem_ready);
   assign pack_load = (state == ST_DATA) && rx_valid;

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE, ST_DONE, ST_ERR: if (start) state_nx = ST_REQ;
         ST_REQ:   if (tx_ready) state_nx = ST_SIZE;
         ST_SIZE: begin
            if (rx_valid && (cnt == 32'd3)) begin
               if (size_full == 32'd0)          state_nx = ST_DONE;
               else if (size_full > MAX_SIZE)   state_nx = ST_ERR;
               else                             state_nx = ST_DATA;
            end
         end
         ST_DATA: begin
            if (rx_valid && ((cnt[1:0] == 2'd3) || (cnt == file_size - 32'd1)))
               state_nx = ST_WRITE;
         end
         ST_WRITE: begin
            if (mem_ready) state_nx = (cnt == file_size) ? ST_DONE : ST_DATA;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // The counter indexes size bytes in SIZE, then is reused as the payload byte count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         done      <= 1'b0;
         cnt       <= '0;
         mem_addr  <= ADDR_W'(BASE_ADDR);
         file_size <= '0;
      end else begin
         state <= state_nx;
         done  <= (state_nx == ST_DONE) && (state != ST_DONE);
         case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  cnt      <= '0;
                  mem_addr <= ADDR_W'(BASE_ADDR);
               end
            end
            ST_SIZE: begin
               if (rx_valid) begin
                  file_size[{cnt[1:0], 3'b000} +: 8] <= rx_data;
                  cnt <= (cnt == 32'd3) ? 32'd0 : cnt + 32'd1;
               end
            end
            ST_DATA:  if (rx_valid)  cnt      <= cnt + 32'd1;
            ST_WRITE: if (mem_ready) mem_addr <= mem_addr + 1'b1;
            default: ;
         endcase
      end
   end

   uart_file_pack u_pack (
      .clk  (clk),
      .rst  (rst),
      .clr  (pack_clr),
      .load (pack_load),
      .lane (cnt[1:0]),
      .din  (rx_data),
      .word (mem_wdata),
      .strb (mem_wstrb)
   );

endmodule

// File: tb/tb_uart_file_loader.sv
// Directed bench for uart_file_loader: host byte driver, memory write log, protocol monitors.
module tb_uart_file_loader;

   localparam int          ADDR_W    = 14;
   localparam int unsigned BASE_ADDR = 16;
   localparam int unsigned MAX_SIZE  = 2**(ADDR_W+2);

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              mem_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wstrb;
   logic              mem_ready;
   logic              busy;
   logic              done;
   logic              error;
   logic [31:0]       file_size;

   int n_checks = 0;
   int n_err    = 0;

   // Monitor state, written only by the always block below
   int          wr_cnt   = 0;
   int          done_cnt = 0;
   int          tx_cnt   = 0;
   int          viol     = 0;
   logic [7:0]  last_tx  = 8'h00;
   logic [31:0] log_addr [0:63];
   logic [31:0] log_data [0:63];
   logic [3:0]  log_strb [0:63];
   logic        hold = 1'b0;
   logic [31:0] h_addr = '0, h_data = '0;
   logic [3:0]  h_strb = '0;

   logic [7:0]  pay [0:15];

   always #5 clk = ~clk;

   uart_file_loader #(
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE_ADDR),
      .MAX_SIZE  (MAX_SIZE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ready (mem_ready),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .file_size (file_size)
   );

   always @(posedge clk) begin
      if (mem_valid && mem_ready) begin
         log_addr[wr_cnt] <= 32'(mem_addr);
         log_data[wr_cnt] <= mem_wdata;
         log_strb[wr_cnt] <= mem_wstrb;
         wr_cnt           <= wr_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (tx_valid && tx_ready) begin
         tx_cnt  <= tx_cnt + 1;
         last_tx <= tx_data;
      end
      hold   <= mem_valid && !mem_ready;
      h_addr <= 32'(mem_addr);
      h_data <= mem_wdata;
      h_strb <= mem_wstrb;
      viol <= viol
            + ((mem_valid && rx_ready) ? 1 : 0)
            + ((hold && (!mem_valid || 32'(mem_addr) != h_addr ||
                         mem_wdata != h_data || mem_wstrb != h_strb)) ? 1 : 0);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int budget = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && budget < 200) begin
         tick();
         budget++;
      end
      if (!rx_ready) check("rx_timeout", 32'(rx_ready), 32'd1);
      else tick();
      rx_valid = 1'b0;
   endtask

   task automatic do_req(input int gap);
      int budget = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("tx_valid_rise", 32'(tx_valid), 32'd1);
      repeat (gap) tick();
      tx_ready = 1'b1;
      while (!tx_valid && budget < 200) begin
         tick();
         budget++;
      end
      if (!tx_valid) check("tx_timeout", 32'(tx_valid), 32'd1);
      else tick();
      tx_ready = 1'b0;
   endtask

   // n_send < size stops early; start_at >= 0 pulses start before that payload byte
   task automatic run_load(input logic [31:0] size, input int n_send,
                           input int gap_max, input int start_at);
      int budget = 0;
      do_req(gap_max == 0 ? 0 : int'($urandom_range(0, gap_max)));
      for (int k = 0; k < 4; k++) send_byte(size[8*k +: 8]);
      for (int n = 0; n < n_send; n++) begin
         if (n == start_at) begin
            start = 1'b1;
            tick();
            start = 1'b0;
         end
         if (gap_max != 0) repeat ($urandom_range(0, gap_max)) tick();
         send_byte(pay[n]);
      end
      if (32'(n_send) == size) begin
         while (busy && budget < 200) begin
            tick();
            budget++;
         end
         check("done_timeout", 32'(busy), 32'd0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_valid"},  32'(tx_valid),  32'd0);
      check({tag, "_rx_ready"},  32'(rx_ready),  32'd0);
      check({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
      check({tag, "_busy"},      32'(busy),      32'd0);
      check({tag, "_done"},      32'(done),      32'd0);
      check({tag, "_error"},     32'(error),     32'd0);
      check({tag, "_tx_data"},   32'(tx_data),   32'h02);
      check({tag, "_mem_addr"},  32'(mem_addr),  BASE_ADDR);
      check({tag, "_mem_wdata"}, mem_wdata,      32'h0);
      check({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'h0);
      check({tag, "_file_size"}, file_size,      32'h0);
   endtask

   task automatic set_pay8();
      for (int i = 0; i < 8; i++) pay[i] = 8'((i + 1) * 8'h11);
   endtask

   initial begin
      int w0, d0, t0;
      rst = 1'b1; start = 1'b0; tx_ready = 1'b0;
      rx_data = 8'h00; rx_valid = 1'b0; mem_ready = 1'b1;
      for (int i = 0; i < 16; i++) pay[i] = 8'h00;
      repeat (2) tick();
      check_reset_outputs("rst");
      rst = 1'b0;
      tick();

      // Basic load of 8 bytes
      set_pay8();
      w0 = wr_cnt; d0 = done_cnt; t0 = tx_cnt;
      run_load(32'd8, 8, 0, -1);
      tick();
      check("basic_txcnt", 32'(tx_cnt - t0), 32'd1);
      check("basic_txbyte", 32'(last_tx), 32'h02);
      check("basic_size", file_size, 32'd8);
      check("basic_nwr", 32'(wr_cnt - w0), 32'd2);
      check("basic_a0", log_addr[w0],   BASE_ADDR);
      check("basic_d0", log_data[w0],   32'h44332211);
      check("basic_s0", 32'(log_strb[w0]), 32'hF);
      check("basic_a1", log_addr[w0+1], BASE_ADDR + 1);
      check("basic_d1", log_data[w0+1], 32'h88776655);
      check("basic_s1", 32'(log_strb[w0+1]), 32'hF);
      check("basic_done", 32'(done_cnt - d0), 32'd1);

      // Partial final word
      w0 = wr_cnt; d0 = done_cnt;
      run_load(32'd5, 5, 0, -1);
      tick();
      check("part_nwr", 32'(wr_cnt - w0), 32'd2);
      check("part_d0", log_data[w0], 32'h44332211);
      check("part_a1", log_addr[w0+1], BASE_ADDR + 1);
      check("part_d1", log_data[w0+1], 32'h00000055);
      check("part_s1", 32'(log_strb[w0+1]), 32'h1);
      check("part_done", 32'(done_cnt - d0), 32'd1);

      // Zero size
      w0 = wr_cnt; d0 = done_cnt;
      run_load(32'd0, 0, 0, -1);
      tick();
      check("zero_nwr", 32'(wr_cnt - w0), 32'd0);
      check("zero_done", 32'(done_cnt - d0), 32'd1);
      check("zero_err", 32'(error), 32'd0);

      // Oversize
      w0 = wr_cnt; d0 = done_cnt;
      run_load(MAX_SIZE + 1, 0, 0, -1);
      check("over_err", 32'(error), 32'd1);
      check("over_rxrdy", 32'(rx_ready), 32'd0);
      repeat (5) tick();
      check("over_err_hold", 32'(error), 32'd1);
      check("over_nwr", 32'(wr_cnt - w0), 32'd0);
      check("over_done", 32'(done_cnt - d0), 32'd0);

      // Backpressure from ERR with random gaps and a 10-cycle memory stall
      pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
      pay[3] = 8'hD4; pay[4] = 8'hE5; pay[5] = 8'hF6;
      w0 = wr_cnt; d0 = done_cnt;
      mem_ready = 1'b0;
      fork
         run_load(32'd6, 6, 3, -1);
         begin
            int budget = 0;
            while (!mem_valid && budget < 300) begin
               tick();
               budget++;
            end
            check("bp_memvalid", 32'(mem_valid), 32'd1);
            repeat (10) tick();
            mem_ready = 1'b1;
         end
      join
      tick();
      check("bp_nwr", 32'(wr_cnt - w0), 32'd2);
      check("bp_a0", log_addr[w0], BASE_ADDR);
      check("bp_d0", log_data[w0], 32'hD4C3B2A1);
      check("bp_d1", log_data[w0+1], 32'h0000F6E5);
      check("bp_s1", 32'(log_strb[w0+1]), 32'h3);
      check("bp_done", 32'(done_cnt - d0), 32'd1);
      check("bp_viol", 32'(viol), 32'd0);

      // Reset after 3 payload bytes, then reload
      set_pay8();
      w0 = wr_cnt; d0 = done_cnt;
      run_load(32'd8, 3, 0, -1);
      #2 rst = 1'b1;
      #2 check_reset_outputs("midrst");
      tick();
      rst = 1'b0;
      tick();
      check("midrst_nwr", 32'(wr_cnt - w0), 32'd0);
      check("midrst_done", 32'(done_cnt - d0), 32'd0);
      pay[0] = 8'h01; pay[1] = 8'h23; pay[2] = 8'h45; pay[3] = 8'h67;
      pay[4] = 8'h89; pay[5] = 8'hAB; pay[6] = 8'hCD; pay[7] = 8'hEF;
      run_load(32'd8, 8, 0, -1);
      tick();
      check("reload_nwr", 32'(wr_cnt - w0), 32'd2);
      check("reload_a0", log_addr[w0], BASE_ADDR);
      check("reload_d0", log_data[w0], 32'h67452301);
      check("reload_d1", log_data[w0+1], 32'hEFCDAB89);
      check("reload_done", 32'(done_cnt - d0), 32'd1);

      // start during DATA is ignored
      set_pay8();
      w0 = wr_cnt; d0 = done_cnt; t0 = tx_cnt;
      run_load(32'd8, 8, 0, 2);
      tick();
      check("busystart_txcnt", 32'(tx_cnt - t0), 32'd1);
      check("busystart_nwr", 32'(wr_cnt - w0), 32'd2);
      check("busystart_a1", log_addr[w0+1], BASE_ADDR + 1);
      check("busystart_d1", log_data[w0+1], 32'h88776655);
      check("busystart_done", 32'(done_cnt - d0), 32'd1);
      check("final_viol", 32'(viol), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
